// File: rtl/led_pattern_pkg.sv
// Shared encodings for the PMOD LED pattern generator: modes, widths, bounce/breathe direction.
// Latency: n/a (types and constants only); backpressure: n/a.
package led_pattern_pkg;

    localparam int MODE_W  = 2;
    localparam int SPEED_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BLINK   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, 1-cycle press pulse on debounced rise.
// Latency: raw edge to press pulse is 2 + DEB_CYCLES + 1 cycles; backpressure: none.
module button_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic but_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= but_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pmod_led_pattern.sv
// LED pattern generator (blink/chase/bounce/breathe) with button-selected mode and speed.
// Latency: pattern state updates on the step edge, led one cycle later; backpressure: none.
module pmod_led_pattern
    import led_pattern_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int DIV        = 10_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int PWM_BITS   = 8,
    parameter int DUTY_STEP  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          but,
    output logic [CHANNELS-1:0] led,
    output logic [MODE_W-1:0]   mode,
    output logic [SPEED_W-1:0]  speed
);

    localparam int POS_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRE_W = $clog2(DIV + 1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(CHANNELS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_INC = PWM_BITS'(DUTY_STEP);
    localparam logic [PWM_BITS-1:0] DUTY_TOP = PWM_BITS'((1 << PWM_BITS) - DUTY_STEP);

    logic mode_press;
    logic speed_press;
    logic any_press;
    logic step;

    mode_e                mode_q,  mode_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [PRE_W-1:0]     pre_q,   pre_d;
    logic [PRE_W-1:0]     period_m1;
    logic [POS_W-1:0]     pos_q,   pos_d;
    logic                 dir_q,   dir_d;
    logic                 phase_q, phase_d;
    logic [PWM_BITS-1:0]  duty_q,  duty_d;
    logic [PWM_BITS-1:0]  pwm_q;
    logic [CHANNELS-1:0]  led_q,   led_d;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .but_i   (but[0]),
        .press_o (mode_press)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk     (clk),
        .rst     (rst),
        .but_i   (but[1]),
        .press_o (speed_press)
    );

    assign any_press = mode_press | speed_press;
    assign period_m1 = PRE_W'(DIV >> speed_q) - PRE_W'(1);
    assign step      = (pre_q == period_m1);

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        pre_d   = step ? '0 : pre_q + PRE_W'(1);
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        duty_d  = duty_q;

        if (mode_press) begin
            mode_d = mode_e'(mode_q + MODE_W'(1));
        end
        if (speed_press) begin
            speed_d = speed_q + SPEED_W'(1);
        end

        // A press restarts the pattern from a clean state and swallows any coincident step.
        if (any_press) begin
            pre_d   = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            phase_d = 1'b0;
            duty_d  = '0;
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: phase_d = ~phase_q;
                MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                MODE_BOUNCE: begin
                    if (CHANNELS > 1) begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = DIR_DOWN;
                                pos_d = pos_q - POS_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (duty_q == DUTY_TOP) begin
                            dir_d  = DIR_DOWN;
                            duty_d = duty_q - DUTY_INC;
                        end else begin
                            duty_d = duty_q + DUTY_INC;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            dir_d  = DIR_UP;
                            duty_d = duty_q + DUTY_INC;
                        end else begin
                            duty_d = duty_q - DUTY_INC;
                        end
                    end
                end
                default: ;
            endcase
        end

        led_d = '0;
        case (mode_q)
            MODE_BLINK:   led_d = {CHANNELS{phase_q}};
            MODE_CHASE,
            MODE_BOUNCE:  led_d[pos_q] = 1'b1;
            MODE_BREATHE: led_d = {CHANNELS{pwm_q < duty_q}};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_BLINK;
            speed_q <= '0;
            pre_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            phase_q <= 1'b0;
            duty_q  <= '0;
            pwm_q   <= '0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            pre_q   <= pre_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_q + PWM_BITS'(1);
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_pmod_led_pattern.sv
// Scoreboard bench for pmod_led_pattern: expected led words queued per stimulus, popped each cycle.
// Latency: n/a; backpressure: n/a.
module tb_pmod_led_pattern;

    localparam int N       = 4;
    localparam int DIV     = 8;
    localparam int DEB     = 4;
    localparam int PWMB    = 4;
    localparam int DSTEP   = 4;
    localparam int EXP_LAT = 2 + DEB + 2;

    localparam int K_BLINK   = 0;
    localparam int K_CHASE   = 1;
    localparam int K_BOUNCE  = 2;
    localparam int K_BREATHE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   but = 2'b00;
    logic [N-1:0] led;
    logic [1:0]   mode;
    logic [1:0]   speed;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int lat;
    int ofs;

    logic [N-1:0] sb_q[$];

    pmod_led_pattern #(
        .CHANNELS   (N),
        .DIV        (DIV),
        .DEB_CYCLES (DEB),
        .PWM_BITS   (PWMB),
        .DUTY_STEP  (DSTEP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .but   (but),
        .led   (led),
        .mode  (mode),
        .speed (speed)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; equals the free-running PWM count.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected led at t cycles after the pattern restart edge.
    function automatic logic [N-1:0] exp_led(input int kind, input int t, input int per, input int cyc_e);
        logic [N-1:0] one;
        int k;
        int b;
        int duty;
        int pwm;
        one = 4'b0001;
        k = (t - 1) / per;
        b = k % 6;
        exp_led = '0;
        case (kind)
            K_BLINK:  exp_led = (k % 2 == 1) ? 4'hF : 4'h0;
            K_CHASE:  exp_led = one << (k % 4);
            K_BOUNCE: exp_led = one << ((b <= 3) ? b : 6 - b);
            default: begin
                duty = ((b <= 3) ? b : 6 - b) * DSTEP;
                pwm  = (cyc_e + t - 1) % 16;
                exp_led = (pwm < duty) ? 4'hF : 4'h0;
            end
        endcase
    endfunction

    task automatic sb_push(input int kind, input int t0, input int n, input int per, input int cyc_e);
        for (int t = t0; t < t0 + n; t++) sb_q.push_back(exp_led(kind, t, per, cyc_e));
    endtask

    task automatic sb_drain(input string tag);
        while (sb_q.size() > 0) begin
            tick(1);
            chk(tag, 32'(led), 32'(sb_q.pop_front()));
        end
    endtask

    // Hold buttons for 'hold' cycles; report cycles to the mode/speed change and cycles since it.
    task automatic press(input logic [1:0] mask, input int hold, output int lat_o, output int ofs_o);
        logic [3:0] prev;
        tick(8);
        prev  = {mode, speed};
        but   = mask;
        lat_o = -1;
        ofs_o = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (lat_o < 0 && {mode, speed} != prev) lat_o = i;
            if (i == hold) but = 2'b00;
            if (i >= hold && lat_o >= 0) begin
                ofs_o = i - lat_o;
                break;
            end
        end
        but = 2'b00;
        chk("press_latency", 32'(lat_o), 32'(EXP_LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        but = 2'b00;
        tick(2);
        rst = 1'b0;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_mode", 32'(mode), 32'h0);
        chk("reset_speed", 32'(speed), 32'h0);
        sb_push(K_BLINK, 1, 25, DIV, 0);
        sb_drain("blink_after_reset");

        but = 2'b01;
        tick(3);
        but = 2'b00;
        tick(12);
        chk("glitch_mode", 32'(mode), 32'h0);

        press(2'b01, 10, lat, ofs);
        chk("chase_mode", 32'(mode), 32'h1);
        sb_push(K_CHASE, ofs + 1, 38, DIV, 0);
        sb_drain("chase_seq");
        chk("chase_mode_once", 32'(mode), 32'h1);

        press(2'b01, 8, lat, ofs);
        chk("bounce_mode", 32'(mode), 32'h2);
        sb_push(K_BOUNCE, ofs + 1, 48, DIV, 0);
        sb_drain("bounce_seq");

        for (int s = 1; s <= 3; s++) begin
            press(2'b10, 8, lat, ofs);
            chk("speed_step", 32'(speed), 32'(s));
        end
        chk("speed_keeps_mode", 32'(mode), 32'h2);
        sb_push(K_BOUNCE, ofs + 1, 12, 1, 0);
        sb_drain("bounce_fast");
        press(2'b10, 8, lat, ofs);
        chk("speed_wrap", 32'(speed), 32'h0);
        sb_push(K_BOUNCE, ofs + 1, 16, DIV, 0);
        sb_drain("prescaler_restart");

        press(2'b01, 8, lat, ofs);
        chk("breathe_mode", 32'(mode), 32'h3);
        sb_push(K_BREATHE, ofs + 1, 56, DIV, cyc - ofs);
        sb_drain("breathe_pwm");

        press(2'b01, 8, lat, ofs);
        chk("mode_wrap", 32'(mode), 32'h0);

        press(2'b11, 8, lat, ofs);
        chk("both_mode", 32'(mode), 32'h1);
        chk("both_speed", 32'(speed), 32'h1);
        sb_push(K_CHASE, ofs + 1, 12, DIV / 2, 0);
        sb_drain("both_chase");

        rst = 1'b1;
        tick(1);
        chk("midrst_led", 32'(led), 32'h0);
        chk("midrst_mode", 32'(mode), 32'h0);
        chk("midrst_speed", 32'(speed), 32'h0);
        rst = 1'b0;
        tick(1);
        chk("midrst_led_after", 32'(led), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
